// File: rtl/lzd_pkg.sv
// Shared definitions for the chunked leading-zero normalizer.
package lzd_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Width needed to hold a leading-zero count of 0..16*nchunk.
    function automatic int calc_lw(input int nchunk);
        return $clog2(CHUNK_W * nchunk + 1);
    endfunction

endpackage

// File: rtl/lzd_norm_ctrl_lzdsixteen.sv
// 16-bit leading-zero detector: p_o = leading zeros, v_o = any bit set.
// p_o is zero when v_o is zero.
module LZDsixteen
    import lzd_pkg::*;
(
    input  logic [15:0] a_i,
    output logic [3:0]  p_o,
    output logic        v_o
);

    // Scan from LSB upward so the highest set bit is the last one recorded.
    always_comb begin
        p_o = 4'd0;
        v_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (a_i[i]) begin
                p_o = 4'(15 - i);
                v_o = 1'b1;
            end else begin
                p_o = p_o;
            end
        end
    end

endmodule

// File: rtl/lzd_norm_ctrl.sv
// Sequential normalizer: walks a shared 16-bit LZD over the operand chunks
// (MSB chunk first), then barrel-shifts the operand so its MSB is one.
module lzd_norm_ctrl
    import lzd_pkg::*;
#(
    parameter int NCHUNK = 3,
    parameter int LW     = calc_lw(NCHUNK)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CHUNK_W*NCHUNK-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHUNK_W*NCHUNK-1:0] out_data,
    output logic [LW-1:0]          out_lzc,
    output logic                   out_zero
);

    localparam int W  = CHUNK_W * NCHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    op_q, op_d;
    logic [LW-1:0]   lzc_q, lzc_d;
    logic [W-1:0]    data_q, data_d;
    logic            zero_q, zero_d;

    logic [CHUNK_W-1:0] chunk_s;
    logic [3:0]         lzd_p_s;
    logic               lzd_v_s;

    // Select the chunk currently under inspection, MSB chunk at k = 0.
    always_comb begin
        chunk_s = op_q[(W - 1) - CHUNK_W * int'(k_q) -: CHUNK_W];
    end

    LZDsixteen u_lzd (
        .a_i (chunk_s),
        .p_o (lzd_p_s),
        .v_o (lzd_v_s)
    );

    // Next-state and datapath updates for the scan/shift sequence.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        op_d    = op_q;
        lzc_d   = lzc_q;
        data_d  = data_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_data;
                    k_d     = KW'(0);
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (lzd_v_s) begin
                    lzc_d   = LW'(CHUNK_W * int'(k_q)) + LW'(lzd_p_s);
                    state_d = SHIFT;
                end else if (k_q == KW'(NCHUNK - 1)) begin
                    lzc_d   = LW'(W);
                    data_d  = {W{1'b0}};
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            SHIFT: begin
                // Single-cycle barrel shift; lzc_q < W here so bits never vanish from the top.
                data_d  = op_q << lzc_q;
                zero_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= KW'(0);
            op_q    <= {W{1'b0}};
            lzc_q   <= {LW{1'b0}};
            data_q  <= {W{1'b0}};
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            op_q    <= op_d;
            lzc_q   <= lzc_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

    // Handshakes decode straight from the state register, so they are mutually exclusive.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = data_q;
        out_lzc   = lzc_q;
        out_zero  = zero_q;
    end

endmodule

// File: tb/tb_lzd_norm_ctrl.sv
// Directed, table-driven bench for lzd_norm_ctrl (NCHUNK = 3, W = 48).
module tb_lzd_norm_ctrl;

    localparam int W  = 48;
    localparam int LW = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [LW-1:0] out_lzc;
    logic          out_zero;

    int tests;
    int fails;

    typedef struct {
        logic [W-1:0]  din;
        logic [W-1:0]  exp_data;
        logic [LW-1:0] exp_lzc;
        logic          exp_zero;
        int            exp_lat;
    } vec_t;

    vec_t vecs [8];

    lzd_norm_ctrl #(.NCHUNK(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lzc   (out_lzc),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one operand, measure latency, check result, then drain it.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        check($sformatf("v%0d in_ready before accept", idx), 64'(in_ready), 64'd1);
        in_data  = v.din;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 48'hDEAD_BEEF_CAFE;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        @(negedge clk);
        check($sformatf("v%0d out_data", idx), 64'(out_data), 64'(v.exp_data));
        check($sformatf("v%0d out_lzc", idx), 64'(out_lzc), 64'(v.exp_lzc));
        check($sformatf("v%0d out_zero", idx), 64'(out_zero), 64'(v.exp_zero));
        check($sformatf("v%0d in_ready in DONE", idx), 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("v%0d in_ready after drain", idx), 64'(in_ready), 64'd1);
        check($sformatf("v%0d out_valid after drain", idx), 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [W-1:0]  held_data;
        logic [LW-1:0] held_lzc;
        int            lat;

        tests = 0;
        fails = 0;

        vecs[0] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 6'd0,  1'b0, 2};
        vecs[1] = '{48'h0000_0000_0001, 48'h8000_0000_0000, 6'd47, 1'b0, 4};
        vecs[2] = '{48'h0000_0012_3456, 48'h91A2_B000_0000, 6'd27, 1'b0, 3};
        vecs[3] = '{48'h0000_0000_0000, 48'h0000_0000_0000, 6'd48, 1'b1, 3};
        vecs[4] = '{48'h0001_0000_0000, 48'h8000_0000_0000, 6'd15, 1'b0, 2};
        vecs[5] = '{48'h0000_8000_0000, 48'h8000_0000_0000, 6'd16, 1'b0, 3};
        vecs[6] = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 6'd0,  1'b0, 2};
        vecs[7] = '{48'h0000_0000_7FFF, 48'hFFFE_0000_0000, 6'd33, 1'b0, 4};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset out_lzc", 64'(out_lzc), 64'd0);
        check("reset out_zero", 64'(out_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: hold the result 5 cycles while in_valid pulses are offered.
        @(negedge clk);
        in_data  = 48'h0000_0012_3456;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20 && !out_valid) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("bp latency", 64'(lat), 64'd3);
        held_data = 48'h91A2_B000_0000;
        held_lzc  = 6'd27;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = c[0];
            in_data  = 48'h0000_0000_0001;
            check($sformatf("bp c%0d out_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("bp c%0d in_ready", c), 64'(in_ready), 64'd0);
            check($sformatf("bp c%0d out_data", c), 64'(out_data), 64'(held_data));
            check($sformatf("bp c%0d out_lzc", c), 64'(out_lzc), 64'(held_lzc));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        check("bp release out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("bp idle stays idle", 64'(in_ready), 64'd1);

        // Reset mid-SCAN: outputs must clear at once, then a fresh operand works.
        @(negedge clk);
        in_data  = 48'h0000_0000_00FF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-rst out_valid", 64'(out_valid), 64'd0);
        check("mid-rst out_data", 64'(out_data), 64'd0);
        check("mid-rst out_lzc", 64'(out_lzc), 64'd0);
        check("mid-rst out_zero", 64'(out_zero), 64'd0);
        check("mid-rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{48'h0000_0000_00FF, 48'hFF00_0000_0000, 6'd40, 1'b0, 4}, 99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
